// File: rtl/id_fetch_control.sv
// ID-stage partner of the fetch unit: IF/ID register, branch/jump resolution,
// operand hazard stalls and stall/flush event counters.
module id_fetch_control #(
   parameter int COUNT_W = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [31:0]        IF_Instruction,
   input  logic [31:0]        IF_PC4,
   input  logic [31:0]        ID_ReadData1,
   input  logic [31:0]        ID_ReadData2,
   input  logic               EX_RegWrite,
   input  logic               EX_MemRead,
   input  logic [4:0]         EX_WriteReg,
   input  logic               MEM_MemRead,
   input  logic [4:0]         MEM_WriteReg,
   output logic               ID_PCSrc,
   output logic [31:0]        ID_new_PC,
   output logic               ID_stall,
   output logic [31:0]        ID_Instruction,
   output logic [31:0]        ID_PC4,
   output logic               ID_Issue,
   output logic [COUNT_W-1:0] Stall_count,
   output logic [COUNT_W-1:0] Flush_count
);

   logic              v;
   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic              is_jump;
   logic              is_jr;
   logic              is_branch;
   logic              taken;
   logic              load_use;
   logic              branch_hazard;
   logic              ex_match;
   logic              mem_match;
   logic signed [31:0] rd1_s;
   logic signed [31:0] rd2_s;
   logic [31:0]       br_offset;

   assign op    = ID_Instruction[31:26];
   assign rs    = ID_Instruction[25:21];
   assign rt    = ID_Instruction[20:16];
   assign funct = ID_Instruction[5:0];
   assign rd1_s = $signed(ID_ReadData1);
   assign rd2_s = $signed(ID_ReadData2);
   assign br_offset = {{14{ID_Instruction[15]}}, ID_Instruction[15:0], 2'b00};

   // Classify the ID instruction and evaluate its branch condition.
   always_comb begin
      is_jump   = 1'b0;
      is_jr     = 1'b0;
      is_branch = 1'b0;
      taken     = 1'b0;
      case (op)
         6'h00: begin
            is_jr = (funct == 6'h08);
            taken = is_jr;
         end
         6'h01: begin
            is_branch = (rt == 5'd0) || (rt == 5'd1);
            taken     = (rt == 5'd0) ? (rd1_s < 0) : ((rt == 5'd1) && (rd1_s >= 0));
         end
         6'h02, 6'h03: begin
            is_jump = 1'b1;
            taken   = 1'b1;
         end
         6'h04: begin
            is_branch = 1'b1;
            taken     = (ID_ReadData1 == ID_ReadData2);
         end
         6'h05: begin
            is_branch = 1'b1;
            taken     = (ID_ReadData1 != ID_ReadData2);
         end
         6'h06: begin
            is_branch = 1'b1;
            taken     = (rd1_s <= 0);
         end
         6'h07: begin
            is_branch = 1'b1;
            taken     = (rd1_s > 0);
         end
         default: ;
      endcase
   end

   assign ex_match  = (EX_WriteReg != 5'd0) && ((EX_WriteReg == rs) || (EX_WriteReg == rt));
   assign mem_match = (MEM_WriteReg != 5'd0) && ((MEM_WriteReg == rs) || (MEM_WriteReg == rt));

   // Branches and jr compare in ID, so they also wait on ALU results in EX and loads in MEM.
   assign load_use      = v && !is_jump && EX_MemRead && ex_match;
   assign branch_hazard = v && (is_branch || is_jr) &&
                          ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));

   assign ID_stall = load_use || branch_hazard;
   assign ID_PCSrc = v && !ID_stall && taken;
   assign ID_Issue = v && !ID_stall;

   always_comb begin
      if (is_jr)
         ID_new_PC = ID_ReadData1;
      else if (is_jump)
         ID_new_PC = {ID_PC4[31:28], ID_Instruction[25:0], 2'b00};
      else
         ID_new_PC = ID_PC4 + br_offset;
   end

   // IF/ID register and event counters; a stall outranks a redirect.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ID_Instruction <= 32'd0;
         ID_PC4         <= 32'd0;
         v              <= 1'b0;
         Stall_count    <= '0;
         Flush_count    <= '0;
      end else if (ID_stall) begin
         Stall_count <= Stall_count + COUNT_W'(1);
      end else if (ID_PCSrc) begin
         ID_Instruction <= 32'd0;
         ID_PC4         <= IF_PC4;
         v              <= 1'b0;
         Flush_count    <= Flush_count + COUNT_W'(1);
      end else begin
         ID_Instruction <= IF_Instruction;
         ID_PC4         <= IF_PC4;
         v              <= 1'b1;
      end
   end

endmodule
